// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-coded counter receive path.
package gray_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    TRACK    = 1'b1
  } state_t;

  // Sample-to-sample binary differences that count as legal steps.
  localparam int unsigned DELTA_HOLD = 0;
  localparam int unsigned DELTA_ADV  = 1;

  // Width-generic Gray to binary conversion on up to 32 bits; bits at w and above return 0.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
    logic [31:0] b;
    logic        acc;
    b   = '0;
    acc = 1'b0;
    for (int unsigned j = 0; j < 32; j++) begin
      if (j < w) begin
        acc          = acc ^ g[w-1-j];
        b[w-1-j]     = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_count_decoder_if.sv
// Sample input and decoded/status outputs of the Gray counter receiver.
interface gray_count_decoder_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ERR_W      = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] gray_in;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] bin_out;
  logic                  advance;
  logic                  step_err;
  logic [ERR_W-1:0]      err_cnt;
  logic                  locked;

  modport master (
    output in_valid, gray_in,
    input  out_valid, bin_out, advance, step_err, err_cnt, locked
  );

  modport slave (
    input  in_valid, gray_in,
    output out_valid, bin_out, advance, step_err, err_cnt, locked
  );
endinterface

// File: rtl/gray2bin_comb.sv
// Purely combinational Gray to binary decoder.
module gray2bin_comb #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] gray,
  output logic [DATA_WIDTH-1:0] bin
);

  // Running XOR from the MSB down: each binary bit is the parity of all Gray bits at or above it.
  always_comb begin
    logic acc;
    bin = '0;
    acc = 1'b0;
    for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
      acc                  = acc ^ gray[DATA_WIDTH-1-j];
      bin[DATA_WIDTH-1-j]  = acc;
    end
  end

endmodule

// File: rtl/gray_count_decoder.sv
// Gray counter receiver: decodes samples, classifies each step, tracks lock and errors.
module gray_count_decoder
  import gray_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ERR_W      = 8,
  parameter int unsigned MAX_CONSEC = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  gray_count_decoder_if.slave  bus
);

  localparam int unsigned CW = (MAX_CONSEC < 2) ? 1 : $clog2(MAX_CONSEC);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic [DATA_WIDTH-1:0] dec_bin;
  logic [DATA_WIDTH-1:0] delta;
  logic [CW-1:0]         consec_q, consec_d;
  logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  advance_q, advance_d;
  logic                  step_err_q, step_err_d;

  gray2bin_comb #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .gray (bus.gray_in),
    .bin  (dec_bin)
  );

  // bin_q doubles as the previous-sample reference, since every accepted sample updates both.
  assign delta = dec_bin - bin_q;

  // Next-state, classification and counter updates for an accepted sample.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    consec_d    = consec_q;
    err_cnt_d   = err_cnt_q;
    out_valid_d = 1'b0;
    advance_d   = 1'b0;
    step_err_d  = 1'b0;
    if (bus.in_valid) begin
      out_valid_d = 1'b1;
      bin_d       = dec_bin;
      unique case (state_q)
        UNLOCKED: begin
          consec_d = '0;
          state_d  = TRACK;
        end
        TRACK: begin
          if (delta == DATA_WIDTH'(DELTA_HOLD)) begin
            consec_d = '0;
          end else if (delta == DATA_WIDTH'(DELTA_ADV)) begin
            advance_d = 1'b1;
            consec_d  = '0;
          end else begin
            step_err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (consec_q == CW'(MAX_CONSEC - 1)) begin
              consec_d = '0;
              state_d  = UNLOCKED;
            end else begin
              consec_d = consec_q + CW'(1);
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  // State and output registers with synchronous reset taking priority over samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      bin_q       <= '0;
      consec_q    <= '0;
      err_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      advance_q   <= 1'b0;
      step_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      consec_q    <= consec_d;
      err_cnt_q   <= err_cnt_d;
      out_valid_q <= out_valid_d;
      advance_q   <= advance_d;
      step_err_q  <= step_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.bin_out   = bin_q;
  assign bus.advance   = advance_q;
  assign bus.step_err  = step_err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.locked    = (state_q == TRACK);

endmodule

// File: tb/tb_gray_count_decoder.sv
// Scoreboard bench for gray_count_decoder (main instance W=4, plus a small-counter instance).
module tb_gray_count_decoder;

  logic clk;
  logic reset;

  gray_count_decoder_if #(.DATA_WIDTH(4), .ERR_W(8)) a_if ();
  gray_count_decoder_if #(.DATA_WIDTH(4), .ERR_W(2)) b_if ();

  gray_count_decoder #(.DATA_WIDTH(4), .ERR_W(8), .MAX_CONSEC(3)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  gray_count_decoder #(.DATA_WIDTH(4), .ERR_W(2), .MAX_CONSEC(8)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] bin;
    logic       adv;
    logic       err;
    logic [7:0] cnt;
    logic       lk;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state for dut_a.
  logic       m_locked;
  logic [3:0] m_prev;
  int         m_consec;
  int         m_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  // Each binary bit is the parity of the Gray bits at and above it.
  function automatic logic [3:0] from_gray(input logic [3:0] g);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_prev   = 4'd0;
    m_consec = 0;
    m_err    = 0;
  endtask

  // Drive one sample into dut_a and push the model's expected result.
  task automatic send(input logic [3:0] g);
    exp_t       e;
    logic [3:0] b;
    logic [3:0] d;
    @(posedge clk);
    #1;
    a_if.in_valid = 1'b1;
    a_if.gray_in  = g;
    b = from_gray(g);
    e.adv = 1'b0;
    e.err = 1'b0;
    if (!m_locked) begin
      m_locked = 1'b1;
      m_consec = 0;
    end else begin
      d = b - m_prev;
      if (d == 4'd1) begin
        e.adv    = 1'b1;
        m_consec = 0;
      end else if (d == 4'd0) begin
        m_consec = 0;
      end else begin
        e.err = 1'b1;
        if (m_err < 255) m_err++;
        m_consec++;
        if (m_consec == 3) begin
          m_locked = 1'b0;
          m_consec = 0;
        end
      end
    end
    m_prev = b;
    e.bin  = b;
    e.cnt  = 8'(m_err);
    e.lk   = m_locked;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    a_if.in_valid = 1'b0;
    b_if.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [3:0] g);
    @(posedge clk);
    #1;
    b_if.in_valid = 1'b1;
    b_if.gray_in  = g;
    @(posedge clk);
    #1;
    b_if.in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Compare every dut_a output beat against the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (a_if.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 32'(a_if.out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("bin_out",  32'(a_if.bin_out),  32'(e.bin));
          check("advance",  32'(a_if.advance),  32'(e.adv));
          check("step_err", 32'(a_if.step_err), 32'(e.err));
          check("err_cnt",  32'(a_if.err_cnt),  32'(e.cnt));
          check("locked",   32'(a_if.locked),   32'(e.lk));
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    a_if.in_valid = 1'b0;
    a_if.gray_in  = '0;
    b_if.in_valid = 1'b0;
    b_if.gray_in  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // 1: sample presented during reset is discarded.
    a_if.in_valid = 1'b1;
    a_if.gray_in  = 4'b0011;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    a_if.in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
    check("rst_bin_out",   32'(a_if.bin_out),   32'd0);
    check("rst_locked",    32'(a_if.locked),    32'd0);
    check("rst_err_cnt",   32'(a_if.err_cnt),   32'd0);
    send(4'b0000);
    idle(1);

    // 2: full sequence from a fresh reset, including the 15 -> 0 wrap.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) send(to_gray(i));
    send(4'b0000);
    idle(1);
    check("seq_err_cnt", 32'(a_if.err_cnt), 32'd0);

    // 3: climb to 5, hold, then advance to 6.
    for (int i = 1; i <= 5; i++) send(to_gray(i));
    send(4'b0111);
    send(4'b0101);

    // 4: illegal jump 6 -> 8 keeps lock, then a clean advance.
    send(4'b1100);
    send(4'b1101);

    // 5: climb 10..15,0,1,2 then three illegal samples drop lock; next relocks cleanly.
    for (int i = 10; i <= 18; i++) send(to_gray(i % 16));
    send(to_gray(7));
    send(to_gray(0));
    send(to_gray(12));
    send(4'b1010);
    // A -1 step is also illegal.
    send(to_gray(11));
    idle(2);
    check("idle_out_valid", 32'(a_if.out_valid), 32'd0);
    check("idle_bin_out",   32'(a_if.bin_out),   32'd11);
    check("idle_err_cnt",   32'(a_if.err_cnt),   32'd5);
    check("idle_locked",    32'(a_if.locked),    32'd1);

    // 6: 2-bit error counter saturates at 3 without losing lock (MAX_CONSEC=8).
    send_b(to_gray(0));
    check("b_capture_err", 32'(b_if.step_err), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      send_b(to_gray((k % 2 == 1) ? 5 : 0));
      check("b_step_err", 32'(b_if.step_err), 32'd1);
      check("b_err_cnt",  32'(b_if.err_cnt),  32'((k > 3) ? 3 : k));
      check("b_locked",   32'(b_if.locked),   32'd1);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("b_rst_err_cnt", 32'(b_if.err_cnt), 32'd0);
    check("b_rst_locked",  32'(b_if.locked),  32'd0);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
